pipestage_skid: RTL and testbench



---
 rtl/pipestage_pkg.sv | 18 +
 rtl/pipestage_slot.sv | 26 ++
 rtl/pipestage_skid.sv | 142 ++++++++++++++
 tb/tb_pipestage_skid.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipestage_pkg.sv
// Shared types and sizing helpers for the elastic pipeline stage.
// State encoding and slot width helper used by pipestage_skid and pipestage_slot.
package pipestage_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Default slot width for the decode->execute latch: {ctrl, data, rd}.
  localparam int SLOT_W = 16 + 128 + 5;

  function automatic int slot_width(input int ctrl_w, input int data_w, input int rd_w);
    return ctrl_w + data_w + rd_w;
  endfunction

endpackage

// File: rtl/pipestage_slot.sv
// One payload slot of the pipeline stage: a register with load and clear.
// Clear wins over load so a flush always empties the slot.
module pipestage_slot
  import pipestage_pkg::*;
#(
  parameter int W = SLOT_W
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipestage_skid.sv
// Elastic valid/ready pipeline stage with a two-entry skid buffer and flush.
// Optional stall/flush statistics counters are built when PIPESTAGE_STATS_EN is defined.
module pipestage_skid
  import pipestage_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 16,
  parameter int RD_W   = 5
`ifdef PIPESTAGE_STATS_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd
`ifdef PIPESTAGE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  localparam int SW = slot_width(CTRL_W, DATA_W, RD_W);

  // Handshake: a word moves when valid and ready are both high at a rising
  // clock edge; valid must not depend on ready, and in_ready/out_valid here
  // are decoded from the state register only.
  state_t        state;
  state_t        state_nxt;
  logic          in_fire;
  logic          out_fire;
  logic          main_load;
  logic          skid_load;
  logic          main_from_skid;
  logic [SW-1:0] in_word;
  logic [SW-1:0] main_d;
  logic [SW-1:0] main_q;
  logic [SW-1:0] skid_q;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign in_word   = {in_ctrl, in_data, in_rd};
  assign main_d    = main_from_skid ? skid_q : in_word;

  always_comb begin
    state_nxt      = state;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_nxt = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_nxt = FULL;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            state_nxt      = BUSY;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  pipestage_slot #(.W(SW)) u_main (
    .clock  (clock),
    .resetn (resetn),
    .load   (main_load),
    .clear  (flush),
    .d      (main_d),
    .q      (main_q)
  );

  pipestage_slot #(.W(SW)) u_skid (
    .clock  (clock),
    .resetn (resetn),
    .load   (skid_load),
    .clear  (flush),
    .d      (in_word),
    .q      (skid_q)
  );

  // Bubbles carry a zero control field so downstream sees a no-op.
  assign out_ctrl = out_valid ? main_q[SW-1 -: CTRL_W] : '0;
  assign out_data = main_q[RD_W +: DATA_W];
  assign out_rd   = main_q[RD_W-1:0];

`ifdef PIPESTAGE_STATS_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush && (state != EMPTY) && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipestage_skid.sv
// Directed self-checking bench for pipestage_skid (stats checks when PIPESTAGE_STATS_EN is defined).
module tb_pipestage_skid;

  localparam int DATA_W = 128;
  localparam int CTRL_W = 16;
  localparam int RD_W   = 5;
  localparam int CNT_W  = 3;

  logic              clock;
  logic              resetn;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic [RD_W-1:0]   in_rd;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [RD_W-1:0]   out_rd;
`ifdef PIPESTAGE_STATS_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
`endif

  logic [DATA_W-1:0] exp_q[$];
  int n_checks;
  int n_pass;

  pipestage_skid #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .RD_W   (RD_W)
`ifdef PIPESTAGE_STATS_EN
    ,
    .CNT_W  (CNT_W)
`endif
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .in_rd     (in_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .out_rd    (out_rd)
`ifdef PIPESTAGE_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c,
                       input logic [DATA_W-1:0] d, input logic [RD_W-1:0] r);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
    in_rd    = r;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_out_valid"}, 128'(out_valid), 128'd0);
    check({tag, "_out_ctrl"},  128'(out_ctrl),  128'd0);
    check({tag, "_in_ready"},  128'(in_ready),  128'd1);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    resetn    = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, '0, '0);
    #12;
    check_bubble("reset");
    check("reset_out_data", 128'(out_data), 128'd0);
    check("reset_out_rd",   128'(out_rd),   128'd0);
`ifdef PIPESTAGE_STATS_EN
    check("reset_stall_cnt", 128'(stall_cnt), 128'd0);
    check("reset_flush_cnt", 128'(flush_cnt), 128'd0);
`endif
    resetn = 1'b1;

    // Single word, one-cycle latency
    out_ready = 1'b1;
    drive(1'b1, 16'h00A5, 128'd1, 5'd3);
    tick();
    drive(1'b0, '0, '0, '0);
    check("single_out_valid", 128'(out_valid), 128'd1);
    check("single_out_ctrl",  128'(out_ctrl),  128'h00A5);
    check("single_out_data",  128'(out_data),  128'd1);
    check("single_out_rd",    128'(out_rd),    128'd3);
    tick();
    check_bubble("single_drain");

    // Stream of 8 words at full throughput
    for (int i = 0; i < 8; i++) begin
      check("stream_in_ready", 128'(in_ready), 128'd1);
      drive(1'b1, CTRL_W'(i + 1), DATA_W'(100 + i), RD_W'(i));
      exp_q.push_back(DATA_W'(100 + i));
      tick();
      check("stream_out_valid", 128'(out_valid), 128'd1);
      check("stream_out_data",  128'(out_data),  128'(exp_q.pop_front()));
      check("stream_out_rd",    128'(out_rd),    128'(i));
    end
    drive(1'b0, '0, '0, '0);
    tick();
    check_bubble("stream_drain");
    check("stream_queue_empty", 128'(exp_q.size()), 128'd0);

    // Back-pressure: A then B fill both slots
    out_ready = 1'b0;
    drive(1'b1, 16'h0011, 128'h0A, 5'd1);
    tick();
    check("bp_busy_in_ready", 128'(in_ready), 128'd1);
    check("bp_busy_data",     128'(out_data), 128'h0A);
    drive(1'b1, 16'h0022, 128'h0B, 5'd2);
    tick();
    drive(1'b0, '0, '0, '0);
    check("bp_full_in_ready", 128'(in_ready), 128'd0);
    check("bp_full_data",     128'(out_data), 128'h0A);
    tick();
    check("bp_hold_data", 128'(out_data), 128'h0A);
    check("bp_hold_ctrl", 128'(out_ctrl), 128'h0011);
    check("bp_hold_rd",   128'(out_rd),   128'd1);
    out_ready = 1'b1;
    tick();
    check("bp_b_in_ready", 128'(in_ready), 128'd1);
    check("bp_b_data",     128'(out_data), 128'h0B);
    check("bp_b_ctrl",     128'(out_ctrl), 128'h0022);
    tick();
    check_bubble("bp_drain");
`ifdef PIPESTAGE_STATS_EN
    check("bp_stall_cnt", 128'(stall_cnt), 128'd2);
`endif

    // Flush in FULL with an in-flight word
    out_ready = 1'b0;
    drive(1'b1, 16'h0033, 128'h0C, 5'd4);
    tick();
    drive(1'b1, 16'h0044, 128'h0D, 5'd5);
    tick();
    check("flush_pre_full", 128'(in_ready), 128'd0);
    drive(1'b1, 16'h0055, 128'h0E, 5'd6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    check_bubble("flush_full");
    check("flush_full_data", 128'(out_data), 128'd0);
    check("flush_full_rd",   128'(out_rd),   128'd0);
`ifdef PIPESTAGE_STATS_EN
    check("flush_full_cnt", 128'(flush_cnt), 128'd1);
`endif
    out_ready = 1'b1;
    tick();
    check("flush_no_ghost", 128'(out_valid), 128'd0);

    // Flush in BUSY with a coincident in_fire; flush in EMPTY is not counted
    drive(1'b1, 16'h0066, 128'h0F, 5'd7);
    tick();
    drive(1'b1, 16'h0077, 128'h10, 5'd8);
    flush = 1'b1;
    tick();
    drive(1'b0, '0, '0, '0);
    check_bubble("flush_busy");
    tick();
    flush = 1'b0;
    check("flush_empty_valid", 128'(out_valid), 128'd0);
`ifdef PIPESTAGE_STATS_EN
    check("flush_busy_cnt", 128'(flush_cnt), 128'd2);
`endif

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    drive(1'b1, 16'h0088, 128'h11, 5'd9);
    tick();
    drive(1'b1, 16'h0099, 128'h12, 5'd10);
    tick();
    drive(1'b0, '0, '0, '0);
    check("areset_pre_full", 128'(in_ready), 128'd0);
    #2;
    resetn = 1'b0;
    #1;
    check_bubble("areset");
    check("areset_out_data", 128'(out_data), 128'd0);
    check("areset_out_rd",   128'(out_rd),   128'd0);
`ifdef PIPESTAGE_STATS_EN
    check("areset_stall_cnt", 128'(stall_cnt), 128'd0);
    check("areset_flush_cnt", 128'(flush_cnt), 128'd0);
`endif
    resetn = 1'b1;

    // Stall counting and saturation
    drive(1'b1, 16'h00AA, 128'h13, 5'd11);
    tick();
    drive(1'b0, '0, '0, '0);
    repeat (5) tick();
    check("stall_hold_data", 128'(out_data), 128'h13);
`ifdef PIPESTAGE_STATS_EN
    check("stall_cnt_5", 128'(stall_cnt), 128'd5);
    repeat (4) tick();
    check("stall_cnt_sat", 128'(stall_cnt), 128'd7);
`endif
    out_ready = 1'b1;
    tick();
    check_bubble("final_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
